// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command-frame controller.
// Holds the FSM encodings, the default sync marker and a saturating increment.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    DATA,
    CHK,
    EXEC
  } main_state_t;

  typedef enum logic {
    ACK_IDLE,
    ACK_LOW
  } ack_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_ack.sv
// 4-phase valid/ack_n byte handshake toward the UART receiver.
// Pulses byte_take for exactly one cycle per byte; never re-takes a byte that is still being acknowledged.
module uart_byte_ack
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       take_en,
  output logic       byte_take,
  output logic [7:0] byte_data,
  output logic       rx_ack_n
);

  ack_state_t r_state;
  ack_state_t w_state_next;
  logic       r_ack_n;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ACK_IDLE;
      r_ack_n <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ack_n <= (w_state_next != ACK_LOW);
    end
  end

  always_comb begin
    w_state_next = r_state;
    byte_take    = 1'b0;
    case (r_state)
      ACK_IDLE: begin
        if (rx_valid && take_en) begin
          byte_take    = 1'b1;
          w_state_next = ACK_LOW;
        end
      end
      ACK_LOW: begin
        // rx_valid still high here is the old byte lingering, not a new one
        if (!rx_valid) begin
          w_state_next = ACK_IDLE;
        end
      end
      default: w_state_next = ACK_IDLE;
    endcase
  end

  assign byte_data = rx_data;
  assign rx_ack_n  = r_ack_n;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/DATA/CHK frames from the UART receiver and issues one register
// write or read per good frame; counts checksum and inter-byte timeout faults.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ack_n,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       rd_valid,
  output logic [6:0] rd_addr,
  input  logic       rd_ready,
  output logic [7:0] err_chk_cnt,
  output logic [7:0] err_to_cnt,
  output logic       busy
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  main_state_t     r_state, w_state_next;
  logic [7:0]      r_cmd, w_cmd_next;
  logic [7:0]      r_data, w_data_next;
  logic [7:0]      r_chk, w_chk_next;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_next;
  logic [7:0]      r_err_chk, w_err_chk_next;
  logic [7:0]      r_err_to, w_err_to_next;

  logic            w_take_en;
  logic            w_byte_take;
  logic [7:0]      w_byte;
  logic            w_to_hit;
  logic            w_xfer;

  uart_byte_ack u_byte_ack (
    .clk       (clk),
    .nrst      (nrst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .take_en   (w_take_en),
    .byte_take (w_byte_take),
    .byte_data (w_byte),
    .rx_ack_n  (rx_ack_n)
  );

  assign w_take_en = (r_state != EXEC);
  assign w_to_hit  = (r_to_cnt == TO_LIMIT);
  assign w_xfer    = r_cmd[7] ? wr_ready : rd_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= HUNT;
      r_cmd     <= '0;
      r_data    <= '0;
      r_chk     <= '0;
      r_to_cnt  <= '0;
      r_err_chk <= '0;
      r_err_to  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cmd     <= w_cmd_next;
      r_data    <= w_data_next;
      r_chk     <= w_chk_next;
      r_to_cnt  <= w_to_cnt_next;
      r_err_chk <= w_err_chk_next;
      r_err_to  <= w_err_to_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cmd_next     = r_cmd;
    w_data_next    = r_data;
    w_chk_next     = r_chk;
    w_err_chk_next = r_err_chk;
    w_err_to_next  = r_err_to;

    if (w_byte_take || r_state == HUNT || r_state == EXEC) begin
      w_to_cnt_next = '0;
    end else begin
      w_to_cnt_next = r_to_cnt + TO_W'(1);
    end

    case (r_state)
      HUNT: begin
        if (w_byte_take && w_byte == SYNC_BYTE) begin
          w_state_next = CMD;
          w_chk_next   = SYNC_BYTE;
        end
      end
      CMD: begin
        // An accepted byte always beats a timeout landing in the same cycle
        if (w_byte_take) begin
          w_cmd_next   = w_byte;
          w_chk_next   = r_chk ^ w_byte;
          w_state_next = w_byte[7] ? DATA : CHK;
        end else if (w_to_hit) begin
          w_state_next  = HUNT;
          w_err_to_next = sat_inc8(r_err_to);
        end
      end
      DATA: begin
        if (w_byte_take) begin
          w_data_next  = w_byte;
          w_chk_next   = r_chk ^ w_byte;
          w_state_next = CHK;
        end else if (w_to_hit) begin
          w_state_next  = HUNT;
          w_err_to_next = sat_inc8(r_err_to);
        end
      end
      CHK: begin
        if (w_byte_take) begin
          if (w_byte == r_chk) begin
            w_state_next = EXEC;
          end else begin
            w_state_next   = HUNT;
            w_err_chk_next = sat_inc8(r_err_chk);
          end
        end else if (w_to_hit) begin
          w_state_next  = HUNT;
          w_err_to_next = sat_inc8(r_err_to);
        end
      end
      EXEC: begin
        if (w_xfer) begin
          w_state_next = HUNT;
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  assign wr_valid    = (r_state == EXEC) && r_cmd[7];
  assign rd_valid    = (r_state == EXEC) && !r_cmd[7];
  assign wr_addr     = r_cmd[6:0];
  assign rd_addr     = r_cmd[6:0];
  assign wr_data     = r_data;
  assign err_chk_cnt = r_err_chk;
  assign err_to_cnt  = r_err_to;
  assign busy        = (r_state != HUNT);

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller that sits downstream of the UART byte receiver on the IB FPGA.
- Consumes received bytes over the receiver's 4-phase valid/ack_n handshake.
- Parses SYNC/CMD/DATA/CHK frames and issues single-register write or read requests to the local register bus.
- Backpressures the receiver by withholding ack while a bus transaction is pending.
- Keeps saturating error counters for checksum and inter-byte timeout faults.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYC, 4096, max clk cycles allowed between accepted bytes inside a frame; must be >= 1.

Ports:
clk  in  1  system clock
nrst  in  1  reset
rx_data  in  8  received byte; stable while rx_valid=1
rx_valid  in  1  receiver has a byte; held until it sees rx_ack_n=0, may stay high 1 extra cycle after
rx_ack_n  out  1  active-low byte acknowledge to receiver
wr_valid  out  1  write request pending
wr_addr  out  7  write register address
wr_data  out  8  write data
wr_ready  in  1  bus accepts write when wr_valid & wr_ready
rd_valid  out  1  read request pending
rd_addr  out  7  read register address
rd_ready  in  1  bus accepts read when rd_valid & rd_ready
err_chk_cnt  out  8  checksum-failure count, saturating
err_to_cnt  out  8  timeout count, saturating
busy  out  1  high whenever main FSM is not HUNT

Behaviour:
Reset, clock and reset values:
- Reset nrst, asynchronous, active-low; clock clk.
- Reset values: rx_ack_n=1; wr_valid=0; rd_valid=0; wr_addr, wr_data, rd_addr = 0; both counters = 0; busy=0; FSMs in HUNT / ACK_IDLE.
- Reset mid-frame or mid-transaction drops all state and aborts any pending request. No partial write is issued.

Byte handshake sub-FSM:
- States ACK_IDLE and ACK_LOW.
- A byte is accepted in the cycle where ack state = ACK_IDLE, rx_valid=1, and the main FSM is in HUNT, CMD, DATA or CHK.
- On accept:
  - rx_data is consumed that cycle.
  - rx_ack_n is registered low from the next cycle; state goes to ACK_LOW.
- In ACK_LOW: hold rx_ack_n=0 until rx_valid is sampled 0, then rx_ack_n=1 next cycle and return to ACK_IDLE.
- rx_valid high while in ACK_LOW is never a new byte. This guarantees no double consume.
- In EXEC no byte is accepted. rx_ack_n stays 1 and the receiver stalls.

Main FSM:
- HUNT:
  - Accepted byte == SYNC_BYTE -> CMD, with chk = SYNC_BYTE.
  - Any other byte is discarded silently.
- CMD:
  - Accepted byte b latched as cmd; chk ^= b.
  - b[7]=1 (write) -> DATA; b[7]=0 (read) -> CHK.
  - A SYNC_BYTE value here is treated as CMD; there is no resync.
- DATA: accepted byte latched as data; chk ^= byte; -> CHK.
- CHK:
  - Accepted byte == chk -> EXEC.
  - Otherwise -> HUNT and err_chk_cnt++.
- EXEC:
  - Write: wr_valid=1, wr_addr=cmd[6:0], wr_data=data.
  - Read: rd_valid=1, rd_addr=cmd[6:0].
  - Outputs stay stable until the ready handshake. The transfer cycle is the last valid cycle; valid drops next cycle and the FSM returns to HUNT.
  - Latency: wr_valid/rd_valid rise the cycle after the CHK byte is accepted.

Timeout:
- Counter width clog2(TIMEOUT_CYC+1).
- Cleared on every accepted byte and whenever the FSM is in HUNT or EXEC; otherwise increments.
- On reaching TIMEOUT_CYC in CMD, DATA or CHK: -> HUNT and err_to_cnt++.
- Timeout and byte accept in the same cycle: the byte wins and there is no timeout.

Counters: increment stops at 8'hFF; no wrap.

Decomposition:
- Shared package uart_pkg:
  - Main FSM enum: HUNT, CMD, DATA, CHK, EXEC.
  - Ack FSM enum.
  - Default SYNC_BYTE constant.
  - Saturating-increment function.
- One natural sub-module: uart_byte_ack, the 4-phase handshake sub-FSM. It outputs byte_take pulse, byte and rx_ack_n; input take_en.

Test Plan:
- Write frame A5 85 3C 1C -> one wr_valid transfer with wr_addr=05, wr_data=3C; err counters stay 0.
- Read frame A5 12 B7 -> one rd_valid transfer with rd_addr=12; wr_valid never asserted.
- Junk 00 FF 7E, then A5 85 3C 00 (bad chk) -> no bus request; err_chk_cnt=1; next good frame executes.
- A5 85 then idle for TIMEOUT_CYC cycles -> err_to_cnt=1, busy=0; following A5 01 A4 issues rd_addr=01.
- wr_ready held 0 for 20 cycles with a next frame's byte waiting -> wr_valid/addr/data stable; rx_ack_n stays 1 until transfer; no byte lost.
- 300 bad-checksum frames -> err_chk_cnt saturates at FF.
- nrst asserted mid-DATA -> all outputs at reset values; re-sent full frame executes once.
